// File: rtl/ibex_obi_responder.sv
// OBI memory responder: word array, configurable grant wait states, fixed RvalidLatency response pipe.
// Grant is held off by GntDelay, by MaxOutstanding in flight (unless one retires now) and by preload writes.
module ibex_obi_responder #(
  parameter int MemWords       = 256,
  parameter int GntDelay       = 0,
  parameter int RvalidLatency  = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [31:0]                 addr_i,
  input  logic                        we_i,
  input  logic [3:0]                  be_i,
  input  logic [31:0]                 wdata_i,
  output logic                        rvalid_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o,
  input  logic                        load_we_i,
  input  logic [$clog2(MemWords)-1:0] load_addr_i,
  input  logic [31:0]                 load_wdata_i
);

  localparam int AW   = $clog2(MemWords);
  localparam int OW   = $clog2(MaxOutstanding + 1);
  localparam int LAST = RvalidLatency - 1;

  typedef struct packed {
    logic        vld;
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0]   mem [MemWords];
  resp_t         pipe [RvalidLatency];
  resp_t         stage0;
  logic [2:0]    wait_cnt;
  logic [OW-1:0] outstanding;
  logic [AW-1:0] word_idx;
  logic          addr_err;
  logic          retire;
  logic          can_issue;

  assign word_idx  = addr_i[AW+1:2];
  assign addr_err  = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != '0);
  assign retire    = pipe[LAST].vld;
  assign can_issue = (outstanding < OW'(MaxOutstanding)) || retire;
  assign gnt_o     = rst_ni && req_i && (wait_cnt >= 3'(GntDelay)) && can_issue && !load_we_i;

  // The array is deliberately unreset so preloaded contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end else if (gnt_o && we_i && !addr_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    stage0 = '0;
    if (gnt_o) begin
      stage0.vld     = 1'b1;
      stage0.is_read = !we_i;
      stage0.err     = addr_err;
      stage0.data    = (!we_i && !addr_err) ? mem[word_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt    <= '0;
      outstanding <= '0;
      for (int i = 0; i < RvalidLatency; i++) pipe[i] <= '0;
    end else begin
      // Counts through backpressure stalls too, so a stall never re-imposes GntDelay.
      if (gnt_o || !req_i) begin
        wait_cnt <= '0;
      end else if (wait_cnt != 3'd7) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      case ({gnt_o, retire})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      pipe[0] <= stage0;
      for (int i = 1; i < RvalidLatency; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rvalid_o = rst_ni && pipe[LAST].vld;
  assign err_o    = rvalid_o && pipe[LAST].err;
  assign rdata_o  = (rvalid_o && pipe[LAST].is_read && !pipe[LAST].err) ? pipe[LAST].data : 32'h0;

endmodule

// File: tb/tb_ibex_obi_responder.sv
// Drives three responder configurations and checks them cycle by cycle against a transaction-level model.
module tb_ibex_obi_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req        [N];
  logic [31:0] addr       [N];
  logic        we         [N];
  logic [3:0]  be         [N];
  logic [31:0] wdata      [N];
  logic        load_we    [N];
  logic [7:0]  load_addr  [N];
  logic [31:0] load_wdata [N];
  logic        gnt        [N];
  logic        rvalid     [N];
  logic        err        [N];
  logic [31:0] rdata      [N];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: wait states + pipelining. Instance 2: hits the outstanding limit.
  ibex_obi_responder #(.MemWords(256), .GntDelay(0), .RvalidLatency(1), .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .load_we_i(load_we[0]), .load_addr_i(load_addr[0]), .load_wdata_i(load_wdata[0]));
  ibex_obi_responder #(.MemWords(256), .GntDelay(2), .RvalidLatency(3), .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .load_we_i(load_we[1]), .load_addr_i(load_addr[1]), .load_wdata_i(load_wdata[1]));
  ibex_obi_responder #(.MemWords(256), .GntDelay(1), .RvalidLatency(4), .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
    .load_we_i(load_we[2]), .load_addr_i(load_addr[2]), .load_wdata_i(load_wdata[2]));

  function automatic int gd(int i); return (i == 0) ? 0 : (i == 1) ? 2 : 1; endfunction
  function automatic int rl(int i); return (i == 0) ? 1 : (i == 1) ? 3 : 4; endfunction
  function automatic int mo(int i); return 2; endfunction

  task automatic chk(int i, string tag, logic [31:0] obs, logic [31:0] want);
    nchk++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL inst%0d %s observed=%h expected=%h", i, tag, obs, want);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic [31:0] mm [N][256];
  exp_t        q [N][$];
  int          wcnt [N];
  int          outs [N];
  int          cyc = 0;

  always @(negedge clk) begin
    logic        retire_m, eg, e;
    logic [31:0] rd;
    logic [7:0]  widx;
    exp_t        h;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        chk(i, "rst_gnt", gnt[i], 0);
        chk(i, "rst_rvalid", rvalid[i], 0);
        chk(i, "rst_err", err[i], 0);
        chk(i, "rst_rdata", rdata[i], 0);
        q[i].delete();
        outs[i] = 0;
        wcnt[i] = 0;
        if (load_we[i]) mm[i][load_addr[i]] = load_wdata[i];
      end else begin
        retire_m = (q[i].size() > 0) && (q[i][0].due == cyc);
        eg = req[i] && (wcnt[i] >= gd(i)) && ((outs[i] < mo(i)) || retire_m) && !load_we[i];
        chk(i, "gnt", gnt[i], eg);
        chk(i, "rvalid", rvalid[i], retire_m);
        if (retire_m) begin
          h = q[i].pop_front();
          chk(i, "err", err[i], h.e);
          chk(i, "rdata", rdata[i], h.d);
        end else begin
          chk(i, "rdata_idle", rdata[i], 0);
        end
        if (eg) begin
          e    = (addr[i][1:0] != 2'b00) || (addr[i] >= 32'd1024);
          widx = addr[i][9:2];
          rd   = (!we[i] && !e) ? mm[i][widx] : 32'h0;
          if (we[i] && !e)
            for (int k = 0; k < 4; k++)
              if (be[i][k]) mm[i][widx][8*k +: 8] = wdata[i][8*k +: 8];
          h.due = cyc + rl(i);
          h.e   = e;
          h.d   = rd;
          q[i].push_back(h);
        end
        if (load_we[i]) mm[i][load_addr[i]] = load_wdata[i];
        outs[i] = outs[i] + (eg ? 1 : 0) - (retire_m ? 1 : 0);
        wcnt[i] = (eg || !req[i]) ? 0 : ((wcnt[i] < 7) ? wcnt[i] + 1 : 7);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int i, int w, logic [31:0] d);
    load_we[i] = 1'b1; load_addr[i] = 8'(w); load_wdata[i] = d;
    tick();
    load_we[i] = 1'b0;
  endtask

  task automatic xfer(int i, logic [31:0] a, logic w, logic [3:0] b, logic [31:0] d);
    logic ok;
    ok = 1'b0;
    req[i] = 1'b1; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    if (!ok) chk(i, "gnt_timeout", ok, 1);
  endtask

  task automatic idle(int i, int n);
    req[i] = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #500000;
    $error("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i] = 0; addr[i] = 0; we[i] = 0; be[i] = 0; wdata[i] = 0;
      load_we[i] = 0; load_addr[i] = 0; load_wdata[i] = 0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int w = 0; w < 16; w++)
      for (int i = 0; i < N; i++) load(i, w, (w == 3) ? 32'hDEADBEEF : $urandom);

    // Preloaded read, byte-enable write, read-after-write
    xfer(0, 32'h0C, 0, 4'h0, 0);
    idle(0, 2);
    xfer(0, 32'h0C, 1, 4'b0101, 32'h11223344);
    xfer(0, 32'h0C, 0, 4'h0, 0);
    idle(0, 2);
    // Error responses; the out-of-range write must not alias onto word 0
    xfer(0, 32'h0E, 0, 4'h0, 0);
    xfer(0, 32'h400, 1, 4'hF, 32'hFFFFFFFF);
    xfer(0, 32'h00, 0, 4'h0, 0);
    xfer(0, 32'h400, 0, 4'h0, 0);
    xfer(0, 32'h20, 1, 4'hF, 32'hCAFEF00D);
    xfer(0, 32'h20, 0, 4'h0, 0);
    xfer(0, 32'h20, 1, 4'h0, 32'h0);
    xfer(0, 32'h20, 0, 4'h0, 0);
    idle(0, 2);
    // Load collision: grant suppressed during the preload cycle
    req[0] = 1; addr[0] = 32'h0C; we[0] = 0; be[0] = 0;
    load_we[0] = 1; load_addr[0] = 8'd5; load_wdata[0] = 32'h55AA55AA;
    tick();
    load_we[0] = 0;
    xfer(0, 32'h0C, 0, 4'h0, 0);
    xfer(0, 32'h14, 0, 4'h0, 0);
    idle(0, 3);

    // Wait states + pipelining, four reads with req held high
    for (int k = 0; k < 4; k++) xfer(1, 32'(k * 4), 0, 4'h0, 0);
    idle(1, 6);
    // Backpressure at the outstanding limit
    for (int k = 0; k < 6; k++) xfer(2, 32'(k * 4 + 8), 0, 4'h0, 0);
    idle(2, 8);

    // Randomised traffic on each configuration
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < 60; t++) begin
        case ($urandom_range(0, 9))
          0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
          1:       a = 32'h400 + 32'($urandom_range(0, 255) * 4);
          default: a = 32'($urandom_range(0, 15) * 4);
        endcase
        xfer(i, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 0;
          if ($urandom_range(0, 3) == 0) load(i, $urandom_range(0, 15), $urandom);
          else tick();
        end
      end
      idle(i, 8);
    end

    // Mid-flight reset: in-flight responses are dropped, contents survive
    xfer(1, 32'h0C, 0, 4'h0, 0);
    xfer(1, 32'h10, 0, 4'h0, 0);
    rst_n = 1'b0;
    addr[1] = 32'h0C; we[1] = 0;
    tick();
    rst_n = 1'b1;
    xfer(1, 32'h0C, 0, 4'h0, 0);
    idle(1, 8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ibex_obi_responder.md
# ibex_obi_responder

Memory-side responder for one Ibex OBI-style port (instruction or data). It answers `req`/`gnt`/`rvalid` transactions from the core from a word-organised on-chip array. Grant wait states and fixed response latency are configurable, and in-order multiple outstanding requests are supported. It sits opposite the core's `instr_*` or `data_*` pins in simulation harnesses and on-die test configurations, with a side-band load port to preload contents.

## Interface
- `MemWords`, 256, number of 32-bit words; power of two, 16..4096.
- `GntDelay`, 0, cycles `req_i` must be held before `gnt_o` may assert; 0..7.
- `RvalidLatency`, 1, cycles from grant edge to `rvalid_o`; 1..4.
- `MaxOutstanding`, 2, maximum granted-but-unanswered requests; 1..`RvalidLatency`+1.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_i` in 1: request valid; held by the initiator until granted.
- `gnt_o` out 1: grant; combinational from `req_i` and registered state.
- `addr_i` in 32: byte address.
- `we_i` in 1: 1 = write.
- `be_i` in 4: byte enables for writes.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid, one cycle per granted request.
- `rdata_o` out 32: read data; 0 whenever `rvalid_o`=0 or the response is a write or an error.
- `err_o` out 1: error response; valid only with `rvalid_o`.
- `load_we_i` in 1: preload write strobe.
- `load_addr_i` in log2(`MemWords`): preload word index.
- `load_wdata_i` in 32: preload data, full word.

## Operation
- Handshake: a request is accepted in the cycle where `req_i`=1 and `gnt_o`=1. At most one acceptance per cycle.
- Grant condition: `gnt_o` = `req_i` && `wait_cnt` >= `GntDelay` && (`outstanding` < `MaxOutstanding` || response retiring this cycle) && !`load_we_i`.
- `wait_cnt` (3 bits, saturating): increments each cycle `req_i`=1 and `gnt_o`=0. It clears on a grant or when `req_i`=0.
- Decode: word index = `addr_i`[log2(`MemWords`)+1:2].
  - Error if `addr_i`[1:0]≠0 or `addr_i` >= 4*`MemWords`.
  - An error request is still granted normally, performs no write and returns `err_o`=1 with `rdata_o`=0.
- Write, at the grant edge: bytes with `be_i`[k]=1 are updated; other bytes are kept. `be_i`=0000 is a legal no-op write.
- Read, at the grant edge: the word is captured into pipeline stage 0. The captured value reflects all earlier-granted writes.
- Response pipeline: a shift register of depth `RvalidLatency`, with each entry {valid, is_read, err, data}.
  - Entries advance every cycle.
  - The last stage drives `rvalid_o`, `err_o` and `rdata_o`.
  - Responses are returned strictly in grant order.
- `outstanding` counter:
  - +1 on grant.
  - −1 when `rvalid_o`=1.
  - Unchanged when both happen in the same cycle.
- Load port:
  - When `load_we_i`=1, the full word at `load_addr_i` is written.
  - Grants are suppressed that cycle, so there is no conflict with core writes.
  - Responses already in the pipeline still retire.
- The array has no reset; contents survive `rst_ni`.

## Timing
- Reset values: `gnt_o`=0 (forced while `rst_ni`=0), `rvalid_o`=0, `err_o`=0, `rdata_o`=0. `wait_cnt`=0, `outstanding`=0, all pipeline valid bits=0.
- Reset mid-transaction: every in-flight response is dropped and never delivered. Writes already granted remain in the array.
- `GntDelay`=0 and no stall: `gnt_o` rises in the same cycle as `req_i`.
- `GntDelay`=N: grant in the (N+1)th consecutive cycle of `req_i` high.
- Latency: granted at edge t, so `rvalid_o`=1 during the cycle after edge t+`RvalidLatency`−1. With `RvalidLatency`=1, the response appears the cycle after the grant.
- Throughput: one transaction per cycle when `GntDelay`=0 and `MaxOutstanding` >= `RvalidLatency`.
- Backpressure boundary: at `outstanding`=`MaxOutstanding`, a grant is allowed only in the cycle whose `rvalid_o` retires an entry.
- `wait_cnt` keeps counting during a backpressure stall, so it does not re-impose the delay after the stall.
- Read-after-write to the same word in back-to-back grants: the read returns the new data.

## Test plan
- Reset, preload and read: preload word 3 = 0xDEADBEEF via `load_we_i`. Then read `addr_i`=0x0C with `GntDelay`=0, `RvalidLatency`=1. Expect `gnt_o` in the same cycle, `rvalid_o` next cycle, `rdata_o`=0xDEADBEEF, `err_o`=0.
- Byte-enable write then read: word 3 = 0xDEADBEEF; write 0x11223344 with `be_i`=0101. The following read returns 0xDE22BE44.
- Error responses:
  - `addr_i`=0x0E (misaligned) gives a grant, then `rvalid_o`=1, `err_o`=1, `rdata_o`=0.
  - `addr_i`=0x400 with `MemWords`=256 gives the same response, and no array word changes.
- Wait states and pipelining: `GntDelay`=2, `RvalidLatency`=3, `MaxOutstanding`=2, `req_i` held high with 4 reads.
  - First grant comes in the 3rd request cycle.
  - Responses arrive in order, 3 cycles after each grant.
  - `outstanding` never exceeds 2.
- Load collision: assert `load_we_i` while `req_i` is high. `gnt_o`=0 that cycle, and the grant arrives the next cycle.
- Mid-flight reset: grant 2 reads with `RvalidLatency`=3, then pull `rst_ni` low for 1 cycle.
  - No `rvalid_o` follows.
  - All outputs are 0 during reset.
  - A subsequent read of preloaded data is correct.
